// File: rtl/burst_read_arbiter_pkg.sv
// Shared types and helpers for the burst read arbiter: FSM state encoding,
// default widths and the index-width helper used for owner/watchdog sizing.
package burst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_TIMEOUT    = 1024;

    // Width needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_read_arbiter_if.sv
// Bundle of the DMA-side request bus and the shared memory burst port.
// Handshake: a requester holds rd (and addr) until a cycle with wait_n high
// accepts it; valid and burst_done are single-cycle beat qualifiers with no
// backpressure, and dout is only meaningful while valid is high.
interface burst_read_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);

    logic [NUM_REQ-1:0]            req_rd;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_wait_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_burst_done;
    logic [DATA_WIDTH-1:0]         req_dout;

    logic                          mem_rd;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_dout;
    logic                          mem_wait_n;
    logic                          mem_valid;
    logic                          mem_burst_done;

    // Arbiter view: sinks requests and memory responses, sources the rest.
    modport slave (
        input  req_rd, req_addr,
        input  mem_dout, mem_wait_n, mem_valid, mem_burst_done,
        output req_wait_n, req_valid, req_burst_done, req_dout,
        output mem_rd, mem_addr
    );

    // Environment view: the DMA masters plus the memory controller.
    modport master (
        output req_rd, req_addr,
        output mem_dout, mem_wait_n, mem_valid, mem_burst_done,
        input  req_wait_n, req_valid, req_burst_done, req_dout,
        input  mem_rd, mem_addr
    );

endinterface

// File: rtl/burst_read_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching from
// last+1 upward with wrap-around.
module rr_pick
    import burst_arb_pkg::*;
#(
    parameter  int N = DEF_NUM_REQ,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         any,
    output logic [W-1:0] pick
);

    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        any   = |req;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            int s;
            s = int'(last) + k;
            if (s >= N) s = s - N;
            idx = W'(s);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/burst_read_arbiter.sv
// Shares one burst-read memory port between NUM_REQ DMA masters with
// round-robin grants held from command issue to burst end, plus a watchdog.
module burst_read_arbiter
    import burst_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    localparam int OW         = idx_width(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    burst_read_arbiter_if.slave  bus,
    output logic [OW-1:0]        io_owner,
    output logic                 io_busy,
    output logic                 io_timeout,
    output arb_state_t           io_state
);

    localparam int WW = idx_width(TIMEOUT);

    arb_state_t            state_q, state_n;
    logic [OW-1:0]         owner_q;
    logic [OW-1:0]         last_q;
    logic [WW-1:0]         wd_q;
    logic                  timeout_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  pick_any;
    logic [OW-1:0]         pick_idx;
    logic                  owner_rd;
    logic [ADDR_WIDTH-1:0] owner_addr;

    logic                  accept, withdraw, done, wd_fire;

    logic [NUM_REQ-1:0]    wait_v, valid_v, done_v;
    logic                  mem_rd_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (bus.req_rd),
        .last (last_q),
        .any  (pick_any),
        .pick (pick_idx)
    );

    assign owner_rd   = bus.req_rd[owner_q];
    assign owner_addr = bus.req_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n  = state_q;
        accept   = 1'b0;
        withdraw = 1'b0;
        done     = 1'b0;
        wd_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) state_n = GRANT;
            end
            GRANT: begin
                if (owner_rd && bus.mem_wait_n) begin
                    accept  = 1'b1;
                    state_n = BURST;
                end else if (!owner_rd) begin
                    withdraw = 1'b1;
                    state_n  = IDLE;
                end
            end
            BURST: begin
                // A burst end arriving on the watchdog limit cycle is a clean finish.
                if (bus.mem_burst_done) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    wd_fire = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q   <= '0;
            last_q    <= OW'(NUM_REQ - 1);
            wd_q      <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            if (state_q == IDLE && pick_any) owner_q <= pick_idx;
            if (accept) begin
                wd_q   <= '0;
                addr_q <= owner_addr;
            end else if (state_q == BURST && wd_q != '1) begin
                wd_q <= wd_q + 1'b1;
            end
            if (withdraw || done || wd_fire) last_q <= owner_q;
            if (wd_fire) timeout_q <= 1'b1;
        end
    end

    // Only the owner ever sees wait_n/valid/burst_done; beats outside BURST are dropped.
    always_comb begin
        wait_v     = '0;
        valid_v    = '0;
        done_v     = '0;
        mem_rd_c   = 1'b0;
        mem_addr_c = '0;
        case (state_q)
            GRANT: begin
                mem_rd_c        = owner_rd;
                mem_addr_c      = owner_addr;
                wait_v[owner_q] = bus.mem_wait_n;
            end
            BURST: begin
                mem_addr_c       = addr_q;
                valid_v[owner_q] = bus.mem_valid;
                done_v[owner_q]  = bus.mem_burst_done;
            end
            default: ;
        endcase
    end

    assign bus.req_wait_n     = wait_v;
    assign bus.req_valid      = valid_v;
    assign bus.req_burst_done = done_v;
    assign bus.req_dout       = DATA_WIDTH'(bus.mem_dout);
    assign bus.mem_rd         = mem_rd_c;
    assign bus.mem_addr       = mem_addr_c;

    assign io_owner   = owner_q;
    assign io_busy    = (state_q != IDLE);
    assign io_timeout = timeout_q;
    assign io_state   = state_q;

endmodule

// File: tb/tb_burst_read_arbiter.sv
// Directed and randomized checks of burst_read_arbiter against a round-robin
// grant model kept at transaction level in the bench.
module tb_burst_read_arbiter;
    import burst_arb_pkg::*;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 16;

    logic       clock;
    logic       reset;
    logic [1:0] io_owner;
    logic       io_busy;
    logic       io_timeout;
    arb_state_t io_state;

    burst_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    burst_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .io_owner   (io_owner),
        .io_busy    (io_busy),
        .io_timeout (io_timeout),
        .io_state   (io_state)
    );

    int          total = 0;
    int          bad   = 0;
    int          ref_last;
    logic        exp_to;
    logic [AW-1:0] addr_tab [NR];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Round-robin rule: first requester after the last served one, wrapping.
    function automatic int rr_next(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic load_addrs();
        for (int i = 0; i < NR; i++) bus.req_addr[i*AW +: AW] = addr_tab[i];
    endtask

    task automatic clear_mem();
        bus.mem_wait_n     = 1'b0;
        bus.mem_valid      = 1'b0;
        bus.mem_burst_done = 1'b0;
    endtask

    // Starts in IDLE with requests already driven; runs one full grant/burst.
    task automatic do_burst(input int beats, input int waits);
        int          exp;
        logic [DW-1:0] d;
        exp = rr_next(bus.req_rd, ref_last);
        tick();
        settle();
        chk("grant_owner", io_owner, exp);
        chk("grant_busy", io_busy, 1);
        chk("grant_mem_rd", bus.mem_rd, 1);
        chk("grant_mem_addr", bus.mem_addr, addr_tab[exp]);
        for (int w = 0; w < waits; w++) begin
            bus.mem_wait_n     = 1'b0;
            bus.mem_valid      = 1'($urandom_range(0, 1));
            bus.mem_burst_done = 1'($urandom_range(0, 1));
            settle();
            chk("stall_wait_n", bus.req_wait_n, 0);
            chk("stall_mem_rd", bus.mem_rd, 1);
            chk("stall_valid_dropped", bus.req_valid, 0);
            chk("stall_done_dropped", bus.req_burst_done, 0);
            tick();
        end
        clear_mem();
        bus.mem_wait_n = 1'b1;
        settle();
        chk("accept_wait_n", bus.req_wait_n, 64'(1) << exp);
        tick();
        bus.mem_wait_n = 1'b0;
        for (int b = 0; b < beats; b++) begin
            d = {$urandom, $urandom};
            bus.mem_dout       = d;
            bus.mem_valid      = 1'b1;
            bus.mem_burst_done = (b == beats - 1);
            settle();
            chk("beat_valid", bus.req_valid, 64'(1) << exp);
            chk("beat_done", bus.req_burst_done, (b == beats - 1) ? (64'(1) << exp) : 64'(0));
            chk("beat_dout", bus.req_dout, d);
            chk("beat_mem_rd", bus.mem_rd, 0);
            chk("beat_mem_addr", bus.mem_addr, addr_tab[exp]);
            tick();
        end
        clear_mem();
        ref_last = exp;
        settle();
        chk("burst_end_idle", io_busy, 0);
        chk("timeout_flag", io_timeout, exp_to);
    endtask

    initial begin
        int exp;
        reset              = 1'b0;
        bus.req_rd         = '0;
        bus.req_addr       = '0;
        bus.mem_dout       = '0;
        clear_mem();
        for (int i = 0; i < NR; i++) addr_tab[i] = 32'h1000 * (i + 1);
        load_addrs();
        #2;
        chk("rst_owner", io_owner, 0);
        chk("rst_busy", io_busy, 0);
        chk("rst_timeout", io_timeout, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wait_n", bus.req_wait_n, 0);
        chk("rst_valid", bus.req_valid, 0);
        chk("rst_done", bus.req_burst_done, 0);
        tick();
        reset    = 1'b1;
        ref_last = NR - 1;
        exp_to   = 1'b0;

        // Single master 1, 16 beats; the final burst_done lands on the watchdog limit.
        addr_tab[1] = 32'h80;
        load_addrs();
        bus.req_rd = 3'b010;
        do_burst(16, 0);
        bus.req_rd = 3'b000;

        // All three requesting continuously.
        bus.req_rd = 3'b111;
        for (int r = 0; r < 6; r++) do_burst(8, 0);
        bus.req_rd = 3'b000;

        // Master 2 with a 5-cycle command stall.
        bus.req_rd = 3'b100;
        do_burst(4, 5);
        bus.req_rd = 3'b000;

        // Owner withdraws in GRANT before accept.
        bus.req_rd = 3'b011;
        exp = rr_next(bus.req_rd, ref_last);
        tick();
        settle();
        chk("wd_pre_owner", io_owner, exp);
        bus.req_rd[exp] = 1'b0;
        settle();
        chk("withdraw_mem_rd", bus.mem_rd, 0);
        chk("withdraw_wait_n", bus.req_wait_n, 0);
        tick();
        settle();
        chk("withdraw_idle", io_busy, 0);
        ref_last = exp;
        bus.req_rd = 3'b011;
        do_burst(3, 1);
        bus.req_rd = 3'b000;

        // Watchdog: accepted burst that never ends.
        bus.req_rd = 3'b001;
        exp = rr_next(bus.req_rd, ref_last);
        tick();
        settle();
        chk("to_owner", io_owner, exp);
        bus.mem_wait_n = 1'b1;
        tick();
        bus.mem_wait_n = 1'b0;
        bus.req_rd     = 3'b000;
        for (int c = 0; c < TO; c++) begin
            settle();
            chk("to_still_busy", io_busy, 1);
            chk("to_flag_clear", io_timeout, 0);
            tick();
        end
        settle();
        chk("to_forced_idle", io_busy, 0);
        chk("to_flag_set", io_timeout, 1);
        exp_to   = 1'b1;
        ref_last = exp;
        bus.mem_burst_done = 1'b1;
        bus.mem_valid      = 1'b1;
        settle();
        chk("to_spurious_done", bus.req_burst_done, 0);
        chk("to_spurious_valid", bus.req_valid, 0);
        tick();
        clear_mem();
        settle();
        chk("to_flag_sticky", io_timeout, 1);

        // Randomized request sets, addresses, stalls and burst lengths.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NR; i++) addr_tab[i] = $urandom;
            load_addrs();
            bus.req_rd = 3'($urandom_range(1, 7));
            do_burst($urandom_range(1, 8), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a burst.
        bus.req_rd = 3'b111;
        exp = rr_next(bus.req_rd, ref_last);
        tick();
        bus.mem_wait_n = 1'b1;
        tick();
        bus.mem_wait_n = 1'b0;
        bus.mem_valid  = 1'b1;
        settle();
        chk("pre_rst_valid", bus.req_valid, 64'(1) << exp);
        reset = 1'b0;
        #1;
        chk("arst_busy", io_busy, 0);
        chk("arst_valid", bus.req_valid, 0);
        chk("arst_mem_rd", bus.mem_rd, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_owner", io_owner, 0);
        chk("arst_timeout", io_timeout, 0);
        clear_mem();
        ref_last = NR - 1;
        exp_to   = 1'b0;
        tick();
        reset = 1'b1;
        do_burst(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
